// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signals of the data cache.
// The cache takes the slave view. The pipeline/memory side, or a bench, takes the master view.
interface dcache_ctrl_if;
  logic        cpu_rd;
  logic [3:0]  cpu_w_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        data_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_w_en, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output cpu_rd, cpu_w_en, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | serve load hits; launch a refill on a load miss or a write on a store
// S_REFILL | fetch 4 single-word beats of the line at mem_addr_q
// S_WRITE  | single write-through of the latched store; merge into line on hit
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              st_hit_q, st_hit_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][4];

  // single write port into the line storage
  logic                  arr_we;
  logic [INDEX_BITS-1:0] arr_idx;
  logic [1:0]            arr_word;
  logic [31:0]           arr_wdata;
  logic [3:0]            arr_bmask;
  logic                  tag_we;

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [1:0]            cpu_word;
  logic                  is_store, is_req, cpu_hit;
  logic [INDEX_BITS-1:0] lat_idx;
  logic [TAG_W-1:0]      lat_tag;
  logic [1:0]            lat_word;
  logic                  data_ready;
  logic                  unused_bits;

  assign cpu_idx  = bus.cpu_addr[3+INDEX_BITS:4];
  assign cpu_tag  = bus.cpu_addr[31:4+INDEX_BITS];
  assign cpu_word = bus.cpu_addr[3:2];
  assign is_store = |bus.cpu_w_en;
  assign is_req   = bus.cpu_rd | is_store;
  assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // the in-flight line/word always lives in the latched memory address
  assign lat_idx  = mem_addr_q[3+INDEX_BITS:4];
  assign lat_tag  = mem_addr_q[31:4+INDEX_BITS];
  assign lat_word = mem_addr_q[3:2];

  assign unused_bits = ^{bus.cpu_addr[1:0], mem_addr_q[1:0]};

  assign bus.cpu_rdata  = data_q[cpu_idx][cpu_word];
  assign bus.data_ready = data_ready;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;

  // next-state, memory port and line-write decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    st_hit_d    = st_hit_q;
    arr_we      = 1'b0;
    arr_idx     = lat_idx;
    arr_word    = cnt_q;
    arr_wdata   = bus.mem_rdata;
    arr_bmask   = 4'hF;
    tag_we      = 1'b0;
    data_ready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_ready = !is_req || (!is_store && cpu_hit);
        if (is_store) begin
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
          mem_wdata_d = bus.cpu_wdata;
          mem_wstrb_d = bus.cpu_w_en;
          st_hit_d    = cpu_hit;
        end else if (bus.cpu_rd && !cpu_hit) begin
          state_d          = S_REFILL;
          valid_d[cpu_idx] = 1'b0;
          cnt_d            = 2'd0;
          mem_req_d        = 1'b1;
          mem_we_d         = 1'b0;
          mem_addr_d       = {bus.cpu_addr[31:4], 4'b0000};
        end
      end
      S_REFILL: begin
        if (bus.mem_ack) begin
          arr_we = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // line becomes valid only once every beat is in
            valid_d[lat_idx] = 1'b1;
            tag_we           = 1'b1;
            mem_req_d        = 1'b0;
            state_d          = S_IDLE;
          end else begin
            mem_addr_d[3:2] = cnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          data_ready = 1'b1;
          arr_we     = st_hit_q;
          arr_word   = lat_word;
          arr_wdata  = mem_wdata_q;
          arr_bmask  = mem_wstrb_q;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control and memory-port registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      st_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      st_hit_q    <= st_hit_d;
    end
  end

  // tag and data storage; not reset, since valid gates every use
  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (arr_bmask[b]) data_q[arr_idx][arr_word][8*b +: 8] <= arr_wdata[8*b +: 8];
      end
    end
    if (tag_we) tag_q[arr_idx] <= lat_tag;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: transaction-level cache/memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();
  dcache_ctrl #(.INDEX_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } txn_t;

  int          tests = 0;
  int          fails = 0;
  int          wait_cycles = 0;
  txn_t        txn_q[$];
  logic [31:0] mem_m [bit [31:0]];
  bit          v_m [16];
  logic [23:0] t_m [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    bit [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem_m.exists(k)) return mem_m[k];
    return k * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    bit [31:0]   k;
    k   = {a[31:2], 2'b00};
    cur = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    mem_m[k] = cur;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) v_m[i] = 1'b0;
  endtask

  // memory responder plus per-cycle handshake stability checks
  initial begin
    int   wcnt;
    bit   pend;
    txn_t prev, cur;
    wcnt = 0;
    pend = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && pend) chk("req_held", bus.mem_req, 1'b1);
      if (!rst || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
        pend = 1'b0;
      end else begin
        cur.addr  = bus.mem_addr;
        cur.we    = bus.mem_we;
        cur.strb  = bus.mem_wstrb;
        cur.wdata = bus.mem_wdata;
        if (pend) begin
          chk("hold_addr", cur.addr, prev.addr);
          chk("hold_we", cur.we, prev.we);
          chk("hold_wdata", cur.wdata, prev.wdata);
          chk("hold_wstrb", cur.strb, prev.strb);
        end
        if (wcnt == wait_cycles) begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          pend = 1'b0;
          txn_q.push_back(cur);
          if (cur.we) mem_wr(cur.addr, cur.wdata, cur.strb);
          else bus.mem_rdata = mem_rd(cur.addr);
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
          pend = 1'b1;
          prev = cur;
        end
      end
    end
  end

  // one CPU request, held until data_ready; checked against the model
  task automatic do_req(input logic rd, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wd, output int stalls, output logic [31:0] rdata);
    logic [3:0]  idx;
    logic [23:0] tg;
    bit          store, hit;
    int          exp_st;
    txn_t        exp_q[$];
    txn_t        t;
    logic [31:0] exp_rd;
    idx    = addr[7:4];
    tg     = addr[31:8];
    store  = |wen;
    hit    = v_m[idx] && (t_m[idx] == tg);
    exp_rd = mem_rd(addr);
    if (store) begin
      exp_st  = 1 + wait_cycles;
      t.addr  = {addr[31:2], 2'b00};
      t.we    = 1'b1;
      t.strb  = wen;
      t.wdata = wd;
      exp_q.push_back(t);
    end else if (rd && !hit) begin
      exp_st = 5 + 4 * wait_cycles;
      for (int i = 0; i < 4; i++) begin
        t.addr  = {addr[31:4], 4'b0000} + 32'(4 * i);
        t.we    = 1'b0;
        t.strb  = 4'h0;
        t.wdata = 32'h0;
        exp_q.push_back(t);
      end
    end else begin
      exp_st = 0;
    end

    txn_q.delete();
    @(negedge clk);
    bus.cpu_rd    = rd;
    bus.cpu_w_en  = wen;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    stalls = 0;
    forever begin
      #2;
      if (bus.data_ready === 1'b1) break;
      stalls++;
      if (stalls > 100) begin
        chk("req_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    rdata = bus.cpu_rdata;
    chk("stall_cycles", stalls, exp_st);
    if (rd && !store) chk("load_data", rdata, exp_rd);
    @(posedge clk);
    #1;
    bus.cpu_rd   = 1'b0;
    bus.cpu_w_en = 4'h0;

    chk("txn_count", txn_q.size(), exp_q.size());
    if (txn_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        chk("txn_addr", txn_q[i].addr, exp_q[i].addr);
        chk("txn_we", txn_q[i].we, exp_q[i].we);
        if (exp_q[i].we) begin
          chk("txn_wstrb", txn_q[i].strb, exp_q[i].strb);
          chk("txn_wdata", txn_q[i].wdata, exp_q[i].wdata);
        end
      end
    end
    if (!store && rd && !hit) begin
      v_m[idx] = 1'b1;
      t_m[idx] = tg;
    end
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] exp_a [4];
    int          kind;
    int          cyc;

    bus.cpu_rd    = 1'b0;
    bus.cpu_w_en  = 4'h0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    mem_m[32'h40]   = 32'h11;
    mem_m[32'h44]   = 32'h22;
    mem_m[32'h48]   = 32'h33;
    mem_m[32'h4C]   = 32'h44;
    mem_m[32'h1000] = 32'h1234_5678;
    model_reset();

    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 4'h0);
    chk("rst_data_ready", bus.data_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // first refill: zero-wait memory, known line contents
    wait_cycles = 0;
    do_req(1'b1, 4'h0, 32'h40, 32'h0, st, rd);
    chk("tp_miss_stall", st, 5);
    chk("tp_miss_data", rd, 32'h11);
    exp_a = '{32'h40, 32'h44, 32'h48, 32'h4C};
    chk("tp_refill_beats", txn_q.size(), 4);
    if (txn_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("tp_refill_addr", txn_q[i].addr, exp_a[i]);
    end
    do_req(1'b1, 4'h0, 32'h48, 32'h0, st, rd);
    chk("tp_hit_stall", st, 0);
    chk("tp_hit_data", rd, 32'h33);

    // store word hit, then read it back
    do_req(1'b0, 4'hF, 32'h44, 32'hDEAD_BEEF, st, rd);
    chk("tp_sw_stall", st, 1);
    if (txn_q.size() == 1) begin
      chk("tp_sw_we", txn_q[0].we, 1'b1);
      chk("tp_sw_strb", txn_q[0].strb, 4'hF);
    end else chk("tp_sw_txns", txn_q.size(), 1);
    do_req(1'b1, 4'h0, 32'h44, 32'h0, st, rd);
    chk("tp_sw_readback_stall", st, 0);
    chk("tp_sw_readback", rd, 32'hDEAD_BEEF);

    // store byte miss must not allocate
    do_req(1'b0, 4'h1, 32'h1000, 32'h0000_00AB, st, rd);
    chk("tp_sb_stall", st, 1);
    if (txn_q.size() == 1) chk("tp_sb_strb", txn_q[0].strb, 4'h1);
    else chk("tp_sb_txns", txn_q.size(), 1);
    do_req(1'b1, 4'h0, 32'h1000, 32'h0, st, rd);
    chk("tp_sb_noalloc_stall", st, 5);
    chk("tp_sb_data", rd, 32'h1234_56AB);

    // two wait cycles per beat
    wait_cycles = 2;
    do_req(1'b1, 4'h0, 32'h2010, 32'h0, st, rd);
    chk("tp_wait_stall", st, 13);
    wait_cycles = 0;

    // reset during beat 2 of a refill
    txn_q.delete();
    @(negedge clk);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h80;
    cyc = 0;
    while (txn_q.size() < 2 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    chk("rst_abort_reached_beat2", txn_q.size(), 2);
    #3 rst = 1'b0;
    #1;
    chk("rst_abort_mem_req", bus.mem_req, 1'b0);
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_req(1'b1, 4'h0, 32'h80, 32'h0, st, rd);
    chk("rst_abort_refetch_stall", st, 5);
    chk("rst_abort_refetch_beats", txn_q.size(), 4);

    // index aliasing: same index, different tags
    do_req(1'b1, 4'h0, 32'h40, 32'h0, st, rd);
    chk("alias_a_stall", st, 5);
    chk("alias_a_data", rd, 32'h11);
    do_req(1'b1, 4'h0, 32'h440, 32'h0, st, rd);
    chk("alias_b_stall", st, 5);
    do_req(1'b1, 4'h0, 32'h40, 32'h0, st, rd);
    chk("alias_a2_stall", st, 5);
    chk("alias_a2_data", rd, 32'h11);

    // randomized traffic over a small tag pool to force hits, misses and aliasing
    for (int n = 0; n < 400; n++) begin
      wait_cycles = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)) |
          (32'($urandom_range(0, 1)) << 20);
      if (kind == 0)      do_req(1'b0, 4'h0, a, $urandom, st, rd);
      else if (kind <= 5) do_req(1'b1, 4'h0, a, $urandom, st, rd);
      else if (kind <= 8) do_req(1'b0, 4'($urandom_range(1, 15)), a, $urandom, st, rd);
      else                do_req(1'b1, 4'($urandom_range(1, 15)), a, $urandom, st, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache sitting between the memory stage of the RV32I pipeline and the backing data memory. It consumes the M-stage load indication and byte write enables (`M_dm_w_en`) and returns load data. It drives `data_ready` so that the pipeline holds while a miss refill or a write-through is outstanding. Lines are 4 words; refills are fetched as 4 single-word beats over a req/ack memory port.

## Interface
- `INDEX_BITS`, 4, line index width; the cache holds 2^INDEX_BITS lines.
- `clk  input  1  clock; all state updates on the rising edge`
- `rst  input  1  asynchronous active-low reset`
- `cpu_rd  input  1  M-stage load request`
- `cpu_w_en  input  4  M-stage byte write enables; nonzero means store`
- `cpu_addr  input  32  byte address; [1:0] ignored, [3:2] word, [3+INDEX_BITS:4] index, rest tag`
- `cpu_wdata  input  32  store data, byte lanes aligned to cpu_w_en`
- `cpu_rdata  output  32  load data; valid when data_ready=1 and cpu_rd=1`
- `data_ready  output  1  request completes this cycle; 1 when no request`
- `mem_req  output  1  memory request, registered`
- `mem_we  output  1  1 = write, 0 = read`
- `mem_addr  output  32  word-aligned memory address`
- `mem_wdata  output  32  write data`
- `mem_wstrb  output  4  write byte strobes`
- `mem_ack  input  1  memory accepted or completed the current request`
- `mem_rdata  input  32  read data, valid in the mem_ack cycle`

## Operation
- State per line: valid bit, tag, and 4×32 data words held in registers with asynchronous read.
- FSM states:
  - IDLE: serves hits and detects misses and stores.
  - REFILL: fetches the 4 beats of a line.
  - WRITE: performs a single write-through.
- Request types:
  - Request = `cpu_rd | (|cpu_w_en)`.
  - If both are set, the request is treated as a store.
- IDLE, no request: `data_ready`=1; `cpu_rdata` is don't-care.
- IDLE, load hit (valid[idx] and tag match): `data_ready`=1 in the same cycle; `cpu_rdata`=word[addr[3:2]], combinational.
- IDLE, load miss: `data_ready`=0. At the edge:
  - go to REFILL;
  - clear valid[idx];
  - latch tag and index;
  - set beat counter to 0;
  - set `mem_req`=1, `mem_we`=0, `mem_addr`={tag,idx,2'b00,2'b00}.
- REFILL, each cycle with `mem_ack`=1:
  - write `mem_rdata` into word[cnt];
  - increment cnt;
  - update `mem_addr` word field to cnt+1; `mem_req` stays 1.
- REFILL, `mem_ack` on beat 3:
  - set valid[idx] and tag[idx];
  - set `mem_req`=0;
  - return to IDLE. The held load then hits.
- IDLE, store: `data_ready`=0. At the edge:
  - go to WRITE;
  - latch address, data and strobes into `mem_addr` (with [1:0]=0), `mem_wdata` and `mem_wstrb`;
  - set `mem_req`=1, `mem_we`=1;
  - record whether the store hit.
- WRITE, `mem_ack`=1:
  - `data_ready`=1 in that cycle (combinational from `mem_ack`);
  - at the edge: if the store hit, merge the strobed bytes into the cached word; set `mem_req`=0, `mem_we`=0; return to IDLE.
  - A store miss never allocates.
- Busy states: `data_ready`=0 except as stated above. CPU inputs are ignored while busy; the pipeline holds them stable, and the latched values are used.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Reset (`rst`=0, asynchronous):
  - all valid bits 0; state IDLE; cnt 0;
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` = 0;
  - `data_ready`=1 with no request.
- Tags and data words are not reset.
- Reset mid-REFILL or mid-WRITE:
  - abort immediately; `mem_req` drops asynchronously;
  - no partial line is ever valid, because valid is set only after beat 3;
  - an aborted write may or may not have reached memory.
- Handshake:
  - `mem_req` and the address/data/strobes are stable from assertion until the edge on which `mem_ack`=1 is sampled;
  - back-to-back refill beats are allowed with no idle cycle.
- Load hit latency: 0 stall cycles.
- Load miss with zero-wait memory:
  - miss seen in cycle 0; beats in cycles 1–4; hit in cycle 5;
  - 5 stall cycles, plus any added wait cycles per beat.
- Store with zero-wait memory: detect in cycle 0; ack and `data_ready`=1 in cycle 1 (1 stall cycle).
- Index aliasing: a refill to a valid line with a different tag evicts it with no writeback, which is safe because the cache is write-through.
- Wrap-around: cnt is 2 bits; REFILL exits on the ack when cnt==3 and never wraps into a 5th beat.

## Test plan
- Reset, then load 0x0000_0040 with zero-wait memory returning 0x11,0x22,0x33,0x44:
  - `mem_addr` sequence is 0x40, 0x44, 0x48, 0x4C;
  - `data_ready` is 0 for 5 cycles, then 1 with `cpu_rdata`=0x11;
  - a following load of 0x48 hits with 0x33 and 0 stalls.
- Store sw 0xDEADBEEF to 0x44 after that refill:
  - `mem_we`=1, `mem_wstrb`=1111, `data_ready`=1 on the ack cycle;
  - a load of 0x44 then hits with 0xDEADBEEF.
- Store sb (`cpu_w_en`=0001) 0xAB to 0x1000 (miss):
  - one memory write with `mem_wstrb`=0001;
  - a load of 0x1000 then misses and refills; no allocation occurred.
- Refill with 2 wait cycles per beat:
  - `mem_req` held and `mem_addr` stable during each wait;
  - the stall lasts 13 cycles.
- Assert `rst`=0 during beat 2 of a refill:
  - `mem_req`=0 immediately;
  - the same load afterwards misses and refetches all 4 beats.
- Alias test: load 0x40, then load 0x440 (same index, different tag), then load 0x40:
  - each load misses and refills, and the data returned always matches memory.
